hazard_stall_ctrl: RTL

- Controller for the stall and flush interface of the RISC-V pipeline segment registers (IF/ID/EX/MEM/WB).
- The segment registers consume en/clear. This block produces them: en = ~StallX, clear = FlushX.
- It detects load-use hazards and control redirects (taken branch, jalr, jal), and freezes the pipe during multi-cycle data-memory accesses.
- It keeps a sticky timeout error and saturating performance counters.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/sat_counter.sv | 32 +++
 rtl/hazard_stall_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline stall/flush controller.
//   state_e  : controller FSM states
//   RR_RS1 / RR_RS2 : bit positions inside RegReadD
//   REG_X0   : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_e;

    localparam int         RR_RS1 = 1;
    localparam int         RR_RS2 = 0;
    localparam logic [4:0] REG_X0 = 5'd0;

    // Load-use: the EX load writes a register the ID instruction reads.
    // Writes to x0 never create a dependency.
    function automatic logic load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [1:0] reg_read,
        input logic [4:0] rd,
        input logic       mem_to_reg,
        input logic [2:0] reg_write
    );
        logic w_src_hit;
        w_src_hit = (reg_read[RR_RS1] && (rs1 == rd)) ||
                    (reg_read[RR_RS2] && (rs2 == rd));
        return mem_to_reg && (reg_write != 3'd0) && (rd != REG_X0) && w_src_hit;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk : system clock, rising edge
//   rst : synchronous active-high clear
//   inc : count enable for this cycle
//   cnt : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Generates en (= ~Stall*) and clear (= Flush*) for the IF/ID/EX/MEM/WB
// segment registers: load-use bubbles, control redirects, multi-cycle
// data-memory freezes, plus a sticky memory-timeout flag and two saturating
// performance counters.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   Rs1D, Rs2D, RegReadD   : source registers of the ID instruction
//   RdE, MemToRegE, RegWriteE : destination info of the EX instruction
//   BranchE, JalrE, JalD   : control redirects
//   MemReqM, MemReadyM     : data-memory handshake in MEM
//   Stall{F,D,E,M,W}       : hold stage register (Mealy)
//   Flush{F,D,E,M,W}       : clear stage register (Mealy)
//   MemTimeout             : sticky error flag
//   StallCnt, FlushCnt     : cycles with StallF, redirect events
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; hazards and redirects resolved each cycle
// MEM_WAIT | pipe frozen waiting for MemReadyM, timer counting
// TIMEOUT  | memory never answered; pipe frozen until reset
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 200,
    parameter int TMR_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [1:0]       RegReadD,
    input  logic [4:0]       RdE,
    input  logic             MemToRegE,
    input  logic [2:0]       RegWriteE,
    input  logic             BranchE,
    input  logic             JalrE,
    input  logic             JalD,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushF,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = 1;

    state_e           r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_timeout;

    state_e           w_state_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_timeout_nxt;

    // Vectors ordered {F, D, E, M, W}
    logic [4:0] w_stall;
    logic [4:0] w_flush;
    logic       w_redirect;
    logic       w_lu;
    logic       w_mem_hold;

    assign w_lu       = load_use(Rs1D, Rs2D, RegReadD, RdE, MemToRegE, RegWriteE);
    assign w_mem_hold = MemReqM && !MemReadyM;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_timeout_nxt = r_timeout;
        case (r_state)
            RUN: begin
                if (w_mem_hold) begin
                    w_state_nxt = MEM_WAIT;
                    w_timer_nxt = '0;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    w_state_nxt = RUN;
                end else if (r_timer == TMR_LAST) begin
                    w_state_nxt   = TIMEOUT;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TMR_ONE;
                end
            end
            TIMEOUT: begin
                w_state_nxt = TIMEOUT;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Output logic. A memory freeze masks redirects: the EX instruction is
    // held, so the redirect is seen again on the release cycle.
    always_comb begin
        logic w_use_rules;
        w_stall     = 5'b00000;
        w_flush     = 5'b00000;
        w_redirect  = 1'b0;
        w_use_rules = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_hold) begin
                    w_stall = 5'b11110;
                    w_flush = 5'b00001;
                end else begin
                    w_use_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!MemReadyM) begin
                    w_stall = 5'b11110;
                    w_flush = 5'b00001;
                end else begin
                    w_use_rules = 1'b1;
                end
            end
            TIMEOUT: begin
                w_stall = 5'b11111;
            end
            default: begin
                w_stall = 5'b00000;
            end
        endcase

        if (w_use_rules) begin
            if (BranchE || JalrE) begin
                // ID is squashed, so its load-use and jal do not matter
                w_flush    = 5'b01100;
                w_redirect = 1'b1;
            end else if (w_lu) begin
                w_stall = 5'b11000;
                w_flush = 5'b00100;
            end else if (JalD) begin
                w_flush = 5'b01000;
            end
        end

        if (rst) begin
            w_stall    = 5'b00000;
            w_flush    = 5'b11111;
            w_redirect = 1'b0;
        end
    end

    assign {StallF, StallD, StallE, StallM, StallW} = w_stall;
    assign {FlushF, FlushD, FlushE, FlushM, FlushW} = w_flush;
    assign MemTimeout = r_timeout;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall[4]),
        .cnt (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_redirect),
        .cnt (FlushCnt)
    );

endmodule
